button_event_arbiter: RTL

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin arbiter turning button press pulses into a ready/valid event stream
// Presses park in a pending register and are granted one at a time; presses that hit an already pending bit are counted as drops.
module button_event_arbiter #(
    parameter int NUM_BUTTONS    = 4,
    parameter int IDX_WIDTH      = $clog2(NUM_BUTTONS),
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BUTTONS-1:0]    btn_pulse,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [IDX_WIDTH-1:0]      evt_idx,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NUM_BUTTONS-1:0]      r_pend;
    logic [NUM_BUTTONS-1:0]      w_pend_nxt;
    logic [NUM_BUTTONS-1:0]      w_grant_oh;
    logic [NUM_BUTTONS-1:0]      w_taken;
    logic [NUM_BUTTONS-1:0]      w_drop;
    logic [IDX_WIDTH-1:0]        r_idx;
    logic [IDX_WIDTH-1:0]        r_last;
    logic [IDX_WIDTH-1:0]        w_grant;
    logic [IDX_WIDTH-1:0]        w_pos;
    logic [31:0]                 w_cand;
    logic [DROP_CNT_WIDTH-1:0]   r_drop;
    logic                        w_found;
    logic                        w_load;

    // Search starts just after the last grant so every pending button gets a turn.
    always_comb begin
        w_grant    = '0;
        w_grant_oh = '0;
        w_found    = 1'b0;
        w_cand     = '0;
        w_pos      = '0;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            w_cand = ({{(32-IDX_WIDTH){1'b0}}, r_last} + 32'(k) + 32'd1) % 32'(NUM_BUTTONS);
            w_pos  = w_cand[IDX_WIDTH-1:0];
            if (!w_found && r_pend[w_pos]) begin
                w_found           = 1'b1;
                w_grant           = w_pos;
                w_grant_oh[w_pos] = 1'b1;
            end
        end
    end

    assign w_load     = w_found && ((r_state == ST_IDLE) || evt_ready);
    assign w_taken    = w_load ? w_grant_oh : '0;
    assign w_pend_nxt = btn_pulse | (r_pend & ~w_taken);
    assign w_drop     = btn_pulse & r_pend & ~w_taken;

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = ST_PRESENT;
        end else if ((r_state == ST_PRESENT) && evt_ready) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_idx  <= '0;
            r_last <= IDX_WIDTH'(NUM_BUTTONS - 1);
            r_drop <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_load) begin
                r_idx  <= w_grant;
                r_last <= w_grant;
            end
            // One count per lossy cycle, however many presses were lost in it.
            if ((|w_drop) && (r_drop != '1)) begin
                r_drop <= r_drop + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign evt_valid  = (r_state == ST_PRESENT);
    assign evt_idx    = r_idx;
    assign drop_count = r_drop;

endmodule
